// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath.
// Currents arrive in neuron order; each produces a registered spike result, then a step_done pulse.
module lif_neuron_array #(
  parameter int N_NEURONS    = 16,
  parameter int DATA_W       = 16,
  parameter int FRAC_W       = 8,
  parameter int REFRAC_STEPS = 2,
  localparam int IDX_W       = $clog2(N_NEURONS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic [3:0]               leak_shift,
  input  logic                     state_clear,
  input  logic                     step_start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_current,
  output logic [IDX_W-1:0]         in_idx,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_fired,
  output logic signed [DATA_W-1:0] out_vmem,
  output logic                     step_done,
  output logic [IDX_W:0]           spike_count,
  output logic                     busy
);
  localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam int EW = DATA_W + 2;
  localparam int CW = IDX_W + 1;

  if (N_NEURONS < 2 || FRAC_W >= DATA_W) begin : g_param_check
    $error("lif_neuron_array: unsupported parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [DATA_W-1:0] thr_q;
  logic [3:0]               lsh_q;
  logic [CW-1:0]            cnt_q;
  logic signed [DATA_W-1:0] v_q      [N_NEURONS];
  logic [RW-1:0]            refrac_q [N_NEURONS];

  logic                     out_valid_q, out_fired_q, done_q;
  logic [IDX_W-1:0]         out_idx_q;
  logic signed [DATA_W-1:0] out_vmem_q;

  logic                     hs, refr, fire;
  logic signed [EW-1:0]     v_ext, leak, sum;
  logic signed [DATA_W-1:0] s_sat;

  // Two guard bits make v - leak + I exact before clamping.
  always_comb begin
    hs    = (state_q == S_RUN) && in_valid;
    v_ext = {{2{v_q[idx_q][DATA_W-1]}}, v_q[idx_q]};
    leak  = v_ext >>> lsh_q;
    sum   = v_ext - leak + {{2{in_current[DATA_W-1]}}, in_current};
    if ((&sum[EW-1:DATA_W-1]) || !(|sum[EW-1:DATA_W-1]))
      s_sat = sum[DATA_W-1:0];
    else if (sum[EW-1])
      s_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      s_sat = {1'b0, {(DATA_W-1){1'b1}}};
    refr = (refrac_q[idx_q] != '0);
    fire = !refr && (s_sat >= thr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      thr_q       <= '0;
      lsh_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_fired_q <= 1'b0;
      out_vmem_q  <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
    end else begin
      out_valid_q <= hs;
      done_q      <= (state_q == S_DONE);
      if (hs) begin
        out_idx_q   <= idx_q;
        out_fired_q <= fire;
        out_vmem_q  <= (refr || fire) ? '0 : s_sat;
      end
      case (state_q)
        S_IDLE: begin
          if (state_clear) begin
            for (int i = 0; i < N_NEURONS; i++) begin
              v_q[i]      <= '0;
              refrac_q[i] <= '0;
            end
          end
          if (step_start) begin
            thr_q   <= threshold;
            lsh_q   <= leak_shift;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            if (refr) begin
              refrac_q[idx_q] <= refrac_q[idx_q] - RW'(1);
              v_q[idx_q]      <= '0;
            end else if (fire) begin
              v_q[idx_q]      <= '0;
              refrac_q[idx_q] <= RW'(REFRAC_STEPS);
              cnt_q           <= cnt_q + CW'(1);
            end else begin
              v_q[idx_q]      <= s_sat;
            end
            if (idx_q == IDX_W'(N_NEURONS - 1)) state_q <= S_DONE;
            else                                 idx_q   <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is high, even before the first reset edge.
  assign in_ready    = !reset && (state_q == S_RUN);
  assign in_idx      = in_ready ? idx_q : '0;
  assign busy        = !reset && (state_q != S_IDLE);
  assign out_valid   = !reset && out_valid_q;
  assign out_idx     = reset ? '0 : out_idx_q;
  assign out_fired   = !reset && out_fired_q;
  assign out_vmem    = reset ? '0 : out_vmem_q;
  assign step_done   = !reset && done_q;
  assign spike_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: per-cycle compare against a timestep-level neuron model,
// directed scenarios pinned with hand-computed values, then randomized timesteps.
module tb_lif_neuron_array;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int REF = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] threshold = 16'sd256;
  logic [3:0]           leak_shift = 4'd1;
  logic                 state_clear = 1'b0, step_start = 1'b0, in_valid = 1'b0;
  logic signed [DW-1:0] in_current = '0;
  logic                 in_ready, out_valid, out_fired, step_done, busy;
  logic [IW-1:0]        in_idx, out_idx;
  logic signed [DW-1:0] out_vmem;
  logic [IW:0]          spike_count;

  lif_neuron_array dut (
    .clk(clk), .reset(reset), .threshold(threshold), .leak_shift(leak_shift),
    .state_clear(state_clear), .step_start(step_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_current(in_current), .in_idx(in_idx),
    .out_valid(out_valid), .out_idx(out_idx), .out_fired(out_fired),
    .out_vmem(out_vmem), .step_done(step_done), .spike_count(spike_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: membrane/refractory arrays plus expected visible outputs.
  int mv [N];
  int mr [N];
  int m_ph = 0, m_idx = 0, m_cnt = 0, m_thr = 0, m_ls = 0;
  int e_rdy = 0, e_idx = 0, e_ov = 0, e_oidx = 0, e_of = 0, e_ovm = 0, e_done = 0, e_cnt = 0, e_busy = 0;

  always @(posedge clk) begin
    int s, cur_i;
    cyc++;
    if (reset) begin
      m_ph = 0; m_idx = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) begin mv[i] = 0; mr[i] = 0; end
      e_rdy = 0; e_idx = 0; e_ov = 0; e_done = 0; e_cnt = 0; e_busy = 0;
    end else begin
      e_ov   = 0;
      e_done = (m_ph == 2);
      if (m_ph == 0) begin
        if (state_clear) for (int i = 0; i < N; i++) begin mv[i] = 0; mr[i] = 0; end
        if (step_start) begin
          m_thr = int'(threshold); m_ls = int'(leak_shift);
          m_idx = 0; m_cnt = 0; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (in_valid) begin
          cur_i = int'(in_current);
          e_ov = 1; e_oidx = m_idx;
          if (mr[m_idx] > 0) begin
            mr[m_idx]--; mv[m_idx] = 0; e_of = 0; e_ovm = 0;
          end else begin
            s = mv[m_idx] - (mv[m_idx] >>> m_ls) + cur_i;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (s >= m_thr) begin
              e_of = 1; e_ovm = 0; mv[m_idx] = 0; mr[m_idx] = REF; m_cnt++;
            end else begin
              e_of = 0; e_ovm = s; mv[m_idx] = s;
            end
          end
          if (m_idx == N - 1) m_ph = 2; else m_idx++;
        end
      end else begin
        m_ph = 0;
      end
      e_rdy  = (m_ph == 1) ? 1 : 0;
      e_idx  = (m_ph == 1) ? m_idx : 0;
      e_busy = (m_ph != 0) ? 1 : 0;
      e_cnt  = m_cnt;
    end
  end

  // Capture of DUT results for the literal checks.
  int cap_v [N];
  int cap_f [N];
  int cap_n = 0, done_cnt = 0, last_spk = 0, t_last = 0, t_done = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_in_idx", in_idx, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_vmem", out_vmem, 0);
      chk("rst_step_done", step_done, 0);
      chk("rst_spike_count", spike_count, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("in_ready", in_ready, e_rdy);
      chk("in_idx", in_idx, e_idx);
      chk("out_valid", out_valid, e_ov);
      chk("step_done", step_done, e_done);
      chk("busy", busy, e_busy);
      chk("spike_count", spike_count, e_cnt);
      if (e_ov != 0 && out_valid) begin
        chk("out_idx", out_idx, e_oidx);
        chk("out_fired", out_fired, e_of);
        chk("out_vmem", int'(out_vmem), e_ovm);
      end
      if (out_valid) begin
        cap_v[out_idx] = int'(out_vmem);
        cap_f[out_idx] = int'(out_fired);
        cap_n++;
        if (out_idx == IW'(N - 1)) t_last = cyc;
      end
      if (step_done) begin
        done_cnt++; last_spk = int'(spike_count); t_done = cyc;
      end
    end
  end

  int cur [N];

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // One timestep; abort_at >= 0 asserts reset just before that neuron's handshake.
  task automatic run_step(input bit clr, input int stall_pct, input int abort_at);
    logic signed [DW-1:0] thr_sv;
    logic [3:0]           ls_sv;
    int                   n;
    thr_sv = threshold; ls_sv = leak_shift;
    for (int i = 0; i < N; i++) begin cap_v[i] = -99999; cap_f[i] = -1; end
    cap_n = 0;
    state_clear = clr; step_start = 1'b1;
    tick();
    state_clear = 1'b0; step_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        return;
      end
      n = 0;
      while (stall_pct > 0 && n < 4 && $urandom_range(0, 99) < stall_pct) begin
        in_valid = 1'b0; in_current = DW'($urandom);
        step_start = 1'($urandom_range(0, 1)); state_clear = 1'($urandom_range(0, 1));
        threshold = DW'($urandom); leak_shift = 4'($urandom);
        tick(); n++;
      end
      step_start = 1'b0; state_clear = 1'b0; threshold = thr_sv; leak_shift = ls_sv;
      in_valid = 1'b1; in_current = DW'(cur[i]);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
  endtask

  int exp0  [6] = '{128, 192, 224, 240, 248, 252};
  int exp3v [6] = '{200, 0, 0, 0, 200, 0};
  int exp3f [6] = '{0, 1, 0, 0, 0, 1};

  initial begin
    int d0, r;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", in_ready, 0);

    // Leaky integration on neuron 0, fire/refractory cycle on neuron 3.
    for (int i = 0; i < N; i++) cur[i] = 0;
    cur[0] = 128; cur[3] = 200;
    for (int s = 0; s < 6; s++) begin
      run_step(s == 0, 0, -1);
      chk("t1_vmem0", cap_v[0], exp0[s]);
      chk("t1_fired0", cap_f[0], 0);
      chk("t2_vmem3", cap_v[3], exp3v[s]);
      chk("t2_fired3", cap_f[3], exp3f[s]);
    end

    // Every neuron fires; step_done directly follows the last result.
    for (int i = 0; i < N; i++) cur[i] = 300;
    run_step(1, 0, -1);
    chk("t3_spike_count", last_spk, 16);
    for (int i = 0; i < N; i++) chk("t3_fired", cap_f[i], 1);
    chk("t3_done_latency", t_done - t_last, 1);

    // Negative saturation and firing at the positive rail.
    for (int i = 0; i < N; i++) cur[i] = 0;
    cur[5] = -32768;
    for (int s = 0; s < 3; s++) begin
      run_step(s == 0, 0, -1);
      chk("t4_sat_neg", cap_v[5], -32768);
      chk("t4_nofire", cap_f[5], 0);
    end
    threshold = 16'sd32767; cur[5] = 0; cur[6] = 32767;
    run_step(1, 0, -1);
    chk("t4_fire_max", cap_f[6], 1);
    threshold = 16'sd256;

    // Stalls with spurious start/clear/threshold changes while running.
    for (int i = 0; i < N; i++) cur[i] = $urandom_range(0, 300) - 100;
    d0 = done_cnt;
    run_step(1, 60, -1);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_all_results", cap_n, 16);

    // Abort after neuron 7, then clear+start from zeroed state.
    for (int i = 0; i < N; i++) cur[i] = 10 * i + 1;
    d0 = done_cnt;
    run_step(0, 0, 8);
    repeat (5) tick();
    chk("t6_no_done", done_cnt, d0);
    run_step(1, 0, -1);
    for (int i = 0; i < N; i++) chk("t6_vmem", cap_v[i], 10 * i + 1);

    // Randomized timesteps.
    for (int s = 0; s < 40; s++) begin
      threshold  = DW'($urandom_range(0, 700) - 200);
      leak_shift = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        cur[i] = (r == 0) ? -32768 : (r == 1) ? 32767 : $urandom_range(0, 800) - 400;
      end
      d0 = done_cnt;
      run_step($urandom_range(0, 4) == 0, 25, -1);
      chk("rand_done", done_cnt - d0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
